fpmult_pack_module: RTL and testbench

- Back end of the FP multiplier; the inverse of the operand-prep stage.
- Takes a raw product (sign, biased exponent sum, 48-bit mantissa product) plus the input exception/zero flags.
- Normalizes, rounds to nearest-even, detects overflow/underflow/special cases, and packs an IEEE-754 single-precision word.
- 3-stage valid/ready pipeline sitting between the DSP48E1 mantissa multiplier and the result consumer.

---
 rtl/fpmult_pkg.sv | 30 +++
 rtl/fpmult_round_rne.sv | 26 ++
 rtl/fpmult_pack_module.sv | 168 ++++++++++++++++
 tb/tb_fpmult_pack_module.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpmult_pkg.sv
// Shared constants and types for the FP multiplier back end.
package fpmult_pkg;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [7:0]  EXP_INF = 8'hFF;

    localparam int MANT_W = 23;
    localparam int EXP_W  = 10;
    localparam int PROD_W = 48;

    // Flags = {NaN, Inf, Overflow, Underflow, Inexact}
    localparam int FLAG_NAN = 4;
    localparam int FLAG_INF = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    // InputExc = {any, ANaN, BNaN, AInf, BInf}
    localparam int EXC_ANY  = 4;
    localparam int EXC_ANAN = 3;
    localparam int EXC_BNAN = 2;
    localparam int EXC_AINF = 1;
    localparam int EXC_BINF = 0;

    typedef struct packed {
        logic [31:0] word;
        logic [4:0]  flags;
    } packResult_t;

endpackage

// File: rtl/fpmult_round_rne.sv
// Round-to-nearest-even of a normalized 23-bit mantissa; a carry out of the
// mantissa wraps it to zero and bumps the exponent.
module fpmult_round_rne
    import fpmult_pkg::*;
(
    input  logic                     [MANT_W-1:0] mant,
    input  logic                                  guard,
    input  logic                                  sticky,
    input  logic signed              [EXP_W-1:0]  expIn,
    output logic                     [MANT_W-1:0] mantRnd,
    output logic signed              [EXP_W-1:0]  expRnd,
    output logic                                  inexact
);

    logic              roundUp;
    logic [MANT_W:0]   mantSum;

    always_comb begin
        roundUp = guard & (sticky | mant[0]);
        mantSum = {1'b0, mant} + {{MANT_W{1'b0}}, roundUp};
        mantRnd = mantSum[MANT_W-1:0];
        expRnd  = mantSum[MANT_W] ? (expIn + 10'sd1) : expIn;
        inexact = guard | sticky;
    end

endmodule

// File: rtl/fpmult_pack_module.sv
// FP multiplier back end: normalize, round (RNE), classify and pack an
// IEEE-754 single, as a 3-stage pipeline with a global stall.
module fpmult_pack_module #(
    parameter logic [31:0] QNAN = fpmult_pkg::QNAN,
    parameter int          BIAS = 127
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               Sp,
    input  logic signed [9:0]  Ep,
    input  logic        [47:0] Mp,
    input  logic        [4:0]  InputExc,
    input  logic               Zp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [31:0] P,
    output logic        [4:0]  Flags
);
    import fpmult_pkg::*;

    localparam logic signed [EXP_W-1:0] EXP_OVF = EXP_W'(2 * BIAS + 1);

    logic stall;

    logic                     [MANT_W-1:0] normMant;
    logic                                  normGuard;
    logic                                  normSticky;
    logic signed              [EXP_W-1:0]  normExp;

    logic                                  vld_p0, sign_p0, guard_p0, sticky_p0, zero_p0;
    logic                     [MANT_W-1:0] mant_p0;
    logic signed              [EXP_W-1:0]  exp_p0;
    logic                     [3:0]        exc_p0;

    logic                                  vld_p1, sign_p1, inexact_p1, zero_p1;
    logic                     [MANT_W-1:0] mant_p1;
    logic signed              [EXP_W-1:0]  exp_p1;
    logic                     [3:0]        exc_p1;

    logic                     [MANT_W-1:0] rndMant;
    logic signed              [EXP_W-1:0]  rndExp;
    logic                                  rndInexact;

    packResult_t packed_p1;

    function automatic packResult_t packResult(
        input logic                     sign,
        input logic signed [EXP_W-1:0]  expVal,
        input logic        [MANT_W-1:0] mant,
        input logic                     inexact,
        input logic        [3:0]        exc,
        input logic                     zero
    );
        packResult_t r;
        logic        isInf;
        logic        isNaN;
        r.word  = '0;
        r.flags = '0;
        isInf   = exc[EXC_AINF] | exc[EXC_BINF];
        isNaN   = exc[EXC_ANAN] | exc[EXC_BNAN] | (isInf & zero);
        if (isNaN) begin
            r.word            = QNAN;
            r.flags[FLAG_NAN] = 1'b1;
        end else if (isInf) begin
            r.word            = {sign, EXP_INF, {MANT_W{1'b0}}};
            r.flags[FLAG_INF] = 1'b1;
        end else if (zero) begin
            r.word = {sign, 31'h0};
        end else if (expVal >= EXP_OVF) begin
            r.word            = {sign, EXP_INF, {MANT_W{1'b0}}};
            r.flags[FLAG_INF] = 1'b1;
            r.flags[FLAG_OVF] = 1'b1;
            r.flags[FLAG_INX] = 1'b1;
        end else if (expVal <= 10'sd0) begin
            // No denormal support: anything below the normal range flushes.
            r.word            = {sign, 31'h0};
            r.flags[FLAG_UNF] = 1'b1;
            r.flags[FLAG_INX] = 1'b1;
        end else begin
            r.word            = {sign, expVal[7:0], mant};
            r.flags[FLAG_INX] = inexact;
        end
        return r;
    endfunction

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        if (Mp[PROD_W-1]) begin
            normMant   = Mp[46:24];
            normGuard  = Mp[23];
            normSticky = |Mp[22:0];
            normExp    = Ep + 10'sd1;
        end else begin
            normMant   = Mp[45:23];
            normGuard  = Mp[22];
            normSticky = |Mp[21:0];
            normExp    = Ep;
        end
    end

    fpmult_round_rne uRound (
        .mant    (mant_p0),
        .guard   (guard_p0),
        .sticky  (sticky_p0),
        .expIn   (exp_p0),
        .mantRnd (rndMant),
        .expRnd  (rndExp),
        .inexact (rndInexact)
    );

    assign packed_p1 = packResult(sign_p1, exp_p1, mant_p1, inexact_p1, exc_p1, zero_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0     <= 1'b0;
            sign_p0    <= 1'b0;
            exp_p0     <= '0;
            mant_p0    <= '0;
            guard_p0   <= 1'b0;
            sticky_p0  <= 1'b0;
            exc_p0     <= '0;
            zero_p0    <= 1'b0;
            vld_p1     <= 1'b0;
            sign_p1    <= 1'b0;
            exp_p1     <= '0;
            mant_p1    <= '0;
            inexact_p1 <= 1'b0;
            exc_p1     <= '0;
            zero_p1    <= 1'b0;
            out_valid  <= 1'b0;
            P          <= '0;
            Flags      <= '0;
        end else if (!stall) begin
            // S1: normalize the raw product
            vld_p0 <= in_valid;
            if (in_valid) begin
                sign_p0   <= Sp;
                exp_p0    <= normExp;
                mant_p0   <= normMant;
                guard_p0  <= normGuard;
                sticky_p0 <= normSticky;
                exc_p0    <= InputExc[EXC_ANAN:EXC_BINF];
                zero_p0   <= Zp;
            end
            // S2: round to nearest even
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                sign_p1    <= sign_p0;
                exp_p1     <= rndExp;
                mant_p1    <= rndMant;
                inexact_p1 <= rndInexact;
                exc_p1     <= exc_p0;
                zero_p1    <= zero_p0;
            end
            // S3: classify and pack
            out_valid <= vld_p1;
            if (vld_p1) begin
                P     <= packed_p1.word;
                Flags <= packed_p1.flags;
            end
        end
    end

endmodule

// File: tb/tb_fpmult_pack_module.sv
// Table-driven bench with an expected-result queue for fpmult_pack_module.
module tb_fpmult_pack_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        Sp;
    logic [9:0]  Ep;
    logic [47:0] Mp;
    logic [4:0]  InputExc;
    logic        Zp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] P;
    logic [4:0]  Flags;

    typedef struct {
        string       name;
        logic        sp;
        logic [9:0]  ep;
        logic [47:0] mp;
        logic [4:0]  exc;
        logic        zp;
        logic [31:0] expP;
        logic [4:0]  expF;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] p;
        logic [4:0]  f;
    } exp_t;

    vec_t vecs[16];
    exp_t expQ[$];

    int nAssert = 0;
    int nFail   = 0;
    int nOut    = 0;

    logic        prevStall = 1'b0;
    logic [31:0] prevP;
    logic [4:0]  prevF;

    fpmult_pack_module dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sp        (Sp),
        .Ep        (Ep),
        .Mp        (Mp),
        .InputExc  (InputExc),
        .Zp        (Zp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .Flags     (Flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] req);
        nAssert++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Output monitor: pops the scoreboard on every handshake and watches stalls.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                nOut++;
                if (expQ.size() == 0) begin
                    check("unexpected output", {P, Flags}, 37'h0);
                    if ({P, Flags} == 37'h0) begin
                        nFail++;
                        $display("FAIL unexpected output: got beat with empty scoreboard");
                    end
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check({e.name, " P"}, {5'h0, P}, {5'h0, e.p});
                    check({e.name, " Flags"}, {32'h0, Flags}, {32'h0, e.f});
                end
            end
            if (out_valid && !out_ready) begin
                check("in_ready during stall", {36'h0, in_ready}, 37'h0);
                if (prevStall) begin
                    check("P held in stall", {P, Flags}, {prevP, prevF});
                end
                prevStall = 1'b1;
            end else begin
                prevStall = 1'b0;
            end
            prevP = P;
            prevF = Flags;
        end else begin
            prevStall = 1'b0;
        end
    end

    task automatic sendBeat(input vec_t v);
        int waitCnt;
        waitCnt = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        Sp       = v.sp;
        Ep       = v.ep;
        Mp       = v.mp;
        InputExc = v.exc;
        Zp       = v.zp;
        @(negedge clk);
        while (!in_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            check({v.name, " accept timeout"}, {36'h0, in_ready}, 37'h1);
        end else begin
            expQ.push_back('{v.name, v.expP, v.expF});
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " drain"}, 37'(expQ.size()), 37'h0);
    endtask

    initial begin
        int outBase;
        vecs[0]  = '{"normal",       1'b0, 10'd128,  48'h600000000000, 5'b00000, 1'b0, 32'h40400000, 5'b00000};
        vecs[1]  = '{"norm shift",   1'b0, 10'd127,  48'h900000000000, 5'b00000, 1'b0, 32'h40100000, 5'b00000};
        vecs[2]  = '{"round carry",  1'b0, 10'd127,  48'h7FFFFFC00000, 5'b00000, 1'b0, 32'h40000000, 5'b00001};
        vecs[3]  = '{"overflow",     1'b0, 10'd254,  48'h800000000000, 5'b00000, 1'b0, 32'h7F800000, 5'b01101};
        vecs[4]  = '{"underflow",    1'b1, 10'd0,    48'h400000000000, 5'b00000, 1'b0, 32'h80000000, 5'b00011};
        vecs[5]  = '{"nan in",       1'b1, 10'd128,  48'h600000000000, 5'b11000, 1'b0, 32'h7FC00000, 5'b10000};
        vecs[6]  = '{"inf times 0",  1'b0, 10'd128,  48'h600000000000, 5'b10001, 1'b1, 32'h7FC00000, 5'b10000};
        vecs[7]  = '{"inf in",       1'b1, 10'd128,  48'h600000000000, 5'b10010, 1'b0, 32'hFF800000, 5'b01000};
        vecs[8]  = '{"tie even",     1'b0, 10'd127,  48'h400000400000, 5'b00000, 1'b0, 32'h3F800000, 5'b00001};
        vecs[9]  = '{"tie odd",      1'b0, 10'd127,  48'h400000C00000, 5'b00000, 1'b0, 32'h3F800002, 5'b00001};
        vecs[10] = '{"round to ovf", 1'b0, 10'd253,  48'hFFFFFF800000, 5'b00000, 1'b0, 32'h7F800000, 5'b01101};
        vecs[11] = '{"max normal",   1'b0, 10'd254,  48'h7FFFFF800000, 5'b00000, 1'b0, 32'h7F7FFFFF, 5'b00000};
        vecs[12] = '{"min normal",   1'b0, 10'd0,    48'h800000000000, 5'b00000, 1'b0, 32'h00800000, 5'b00000};
        vecs[13] = '{"neg exp",      1'b0, 10'h3FB,  48'h800000000000, 5'b00000, 1'b0, 32'h00000000, 5'b00011};
        vecs[14] = '{"zero in",      1'b1, 10'd128,  48'h600000000000, 5'b00000, 1'b1, 32'h80000000, 5'b00000};
        vecs[15] = '{"negative",     1'b1, 10'd128,  48'h600000000000, 5'b00000, 1'b0, 32'hC0400000, 5'b00000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Sp        = 1'b0;
        Ep        = '0;
        Mp        = '0;
        InputExc  = '0;
        Zp        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {36'h0, out_valid}, 37'h0);
        check("reset P/Flags", {P, Flags}, 37'h0);
        check("reset in_ready", {36'h0, in_ready}, 37'h1);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) sendBeat(vecs[i]);
        idle();
        waitDrain("table");

        outBase = nOut;
        fork
            begin
                for (int i = 0; i < 6; i++) sendBeat(vecs[i]);
                idle();
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = !(c >= 4 && c <= 7);
                end
            end
        join
        out_ready = 1'b1;
        waitDrain("backpressure");
        check("backpressure beat count", 37'(nOut - outBase), 37'd6);

        sendBeat(vecs[0]);
        sendBeat(vecs[3]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        expQ.delete();
        outBase  = nOut;
        @(posedge clk);
        #1;
        check("mid-flight reset out_valid", {36'h0, out_valid}, 37'h0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post-reset out_valid", {36'h0, out_valid}, 37'h0);
        end
        check("post-reset beat count", 37'(nOut - outBase), 37'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
